// File: rtl/dcache_wb.sv
// rtl/dcache_wb.sv - direct-mapped write-back write-allocate data cache
//
// Sits between the core data port (64-bit doublewords) and a slow line-wide
// data memory. Hits complete in the request cycle; misses stall the core while
// a dirty victim is written back and the 4-doubleword line is refilled.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       synchronous reset, active-high (rst_n=1 resets)
//   proc_read   core load request
//   proc_write  core store request (wins when both are high)
//   proc_addr   byte address bits [31:2]; bit 2 ignored
//   proc_wdata  store data
//   proc_rdata  load data, valid when proc_read & !proc_stall, else 0
//   proc_stall  core must hold its request and freeze
//   mem_read    line refill request (registered)
//   mem_write   line write-back request (registered)
//   mem_addr    line address A[31:5] (registered)
//   mem_wdata   victim line, doubleword 0 in [63:0] (registered)
//   mem_rdata   refill line, doubleword 0 in [63:0]
//   mem_ready   one-cycle pulse: memory accepted/returned a line
module dcache_wb #(
  parameter int NUM_LINES = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [63:0]  proc_wdata,
  output logic [63:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [26:0]  mem_addr,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 27 - IDX_W;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_ALLOCATE  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [255:0]         data_q [NUM_LINES];

  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic [26:0]          mem_addr_q, mem_addr_d;
  logic [255:0]         mem_wdata_q, mem_wdata_d;

  // proc_addr[k] holds A[k+2]: offset A[4:3], index above it, tag on top.
  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             req, hit, wr_hit, refill;
  logic             unused_addr_bit;

  assign off             = proc_addr[2:1];
  assign idx             = proc_addr[3 +: IDX_W];
  assign tag             = proc_addr[29 -: TAG_W];
  assign unused_addr_bit = proc_addr[0];

  assign req    = proc_read | proc_write;
  assign hit    = valid_q[idx] && (tag_q[idx] == tag);
  assign wr_hit = (state_q == S_IDLE) && proc_write && hit;
  assign refill = (state_q == S_ALLOCATE) && mem_ready;

  // Miss is flagged in the same cycle the request arrives, before any FSM move.
  assign proc_stall = (state_q != S_IDLE) || (req && !hit);
  assign proc_rdata = ((state_q == S_IDLE) && proc_read && !proc_write && hit)
                      ? data_q[idx][{off, 6'd0} +: 64] : 64'd0;

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req && !hit) begin
          if (valid_q[idx] && dirty_q[idx]) begin
            state_d     = S_WRITEBACK;
            mem_write_d = 1'b1;
            mem_addr_d  = {tag_q[idx], idx};
            mem_wdata_d = data_q[idx];
          end else begin
            state_d    = S_ALLOCATE;
            mem_read_d = 1'b1;
            mem_addr_d = proc_addr[29:3];
          end
        end else if (wr_hit) begin
          dirty_d[idx] = 1'b1;
        end
      end
      S_WRITEBACK: begin
        // Switch straight from write-back to refill; the two strobes never overlap.
        if (mem_ready) begin
          state_d     = S_ALLOCATE;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = proc_addr[29:3];
        end
      end
      S_ALLOCATE: begin
        if (mem_ready) begin
          state_d      = S_IDLE;
          mem_read_d   = 1'b0;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      data_q[idx][{off, 6'd0} +: 64] <= proc_wdata;
    end
    if (refill) begin
      data_q[idx] <= mem_rdata;
      tag_q[idx]  <= tag;
    end
  end

endmodule

// File: tb/tb_dcache_wb.sv
// tb/tb_dcache_wb.sv - directed scoreboard bench for dcache_wb
module tb_dcache_wb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [63:0]  proc_wdata;
  logic [63:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read, mem_write;
  logic [26:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_ready;

  always #5 clk = ~clk;

  dcache_wb #(.NUM_LINES(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  typedef struct {
    bit           wr;
    logic [26:0]  addr;
    bit           chk;
    logic [255:0] wdata;
  } mem_exp_t;

  mem_exp_t     exp_mem[$];
  logic [63:0]  exp_rd[$];
  logic [255:0] mem_model [logic [26:0]];

  int errors = 0;
  int checks = 0;

  function automatic logic [63:0] pat(input logic [26:0] la, input int k);
    return {5'd0, la, 32'(k)};
  endfunction

  function automatic logic [255:0] line_pat(input logic [26:0] la);
    return {pat(la, 3), pat(la, 2), pat(la, 1), pat(la, 0)};
  endfunction

  function automatic logic [255:0] model_line(input logic [26:0] la);
    if (mem_model.exists(la)) return mem_model[la];
    return line_pat(la);
  endfunction

  task automatic check(input string nm, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic push_mem(input bit wr, input logic [26:0] la, input bit chk, input logic [255:0] wd);
    mem_exp_t e;
    e.wr = wr; e.addr = la; e.chk = chk; e.wdata = wd;
    exp_mem.push_back(e);
  endtask

  // Drive one request and serve memory until the core is released.
  task automatic access(input string nm, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [63:0] wd, input int exp_stalls);
    int stalls = 0;
    int wcnt = 0;
    bit busy = 0;
    bit done = 0;
    mem_exp_t e;
    logic [63:0] er;
    proc_read = rd; proc_write = wr; proc_addr = a[31:2]; proc_wdata = wd;
    #1;
    for (int i = 0; i < 64 && !done; i++) begin
      if (!proc_stall) begin
        done = 1;
      end else begin
        stalls++;
        check({nm, " excl"}, 256'(mem_read & mem_write), 256'(0));
        if (!busy && (mem_read || mem_write)) begin
          busy = 1; wcnt = 0;
          check({nm, " req expected"}, 256'(exp_mem.size() > 0), 256'(1));
          if (exp_mem.size() > 0) begin
            e = exp_mem.pop_front();
            check({nm, " req kind"}, 256'({mem_write, mem_read}), 256'({e.wr, !e.wr}));
            check({nm, " req addr"}, 256'(mem_addr), 256'(e.addr));
            if (e.chk) check({nm, " wb data"}, mem_wdata, e.wdata);
          end
          if (mem_write) mem_model[mem_addr] = mem_wdata;
        end else if (busy) begin
          wcnt++;
        end
        if (busy && wcnt == 4) begin
          mem_ready = 1'b1;
          mem_rdata = model_line(mem_addr);
          busy = 0;
        end
        @(posedge clk); @(negedge clk);
        mem_ready = 1'b0;
        #1;
      end
    end
    check({nm, " released"}, 256'(done), 256'(1));
    check({nm, " stalls"}, 256'(stalls), 256'(exp_stalls));
    check({nm, " mem idle"}, 256'({mem_read, mem_write}), 256'(0));
    if (rd && !wr) begin
      check({nm, " rd expected"}, 256'(exp_rd.size() > 0), 256'(1));
      if (exp_rd.size() > 0) begin
        er = exp_rd.pop_front();
        check({nm, " rdata"}, 256'(proc_rdata), 256'(er));
      end
    end
    @(posedge clk); @(negedge clk);
    proc_read = 1'b0; proc_write = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b1; proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0;
    proc_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset stall", 256'(proc_stall), 256'(0));
    check("reset mem_read", 256'(mem_read), 256'(0));
    check("reset mem_write", 256'(mem_write), 256'(0));
    check("reset mem_addr", 256'(mem_addr), 256'(0));
    check("reset rdata", 256'(proc_rdata), 256'(0));

    // Cold read miss, clean refill.
    push_mem(0, 27'h2, 0, '0); exp_rd.push_back(pat(27'h2, 0));
    access("t1 rd 0x40", 1, 0, 32'h40, 64'd0, 6);
    exp_rd.push_back(pat(27'h2, 1));
    access("t2 rd 0x48", 1, 0, 32'h48, 64'd0, 0);

    // Write hit, then read it back.
    access("t3 wr 0x48", 0, 1, 32'h48, 64'hDEADBEEF00000001, 0);
    exp_rd.push_back(64'hDEADBEEF00000001);
    access("t3 rd 0x48", 1, 0, 32'h48, 64'd0, 0);

    // Conflict miss on a dirty line: write-back, then refill.
    push_mem(1, 27'h2, 1, {pat(27'h2, 3), pat(27'h2, 2), 64'hDEADBEEF00000001, pat(27'h2, 0)});
    push_mem(0, 27'hA, 0, '0); exp_rd.push_back(pat(27'hA, 1));
    access("t4 rd 0x148", 1, 0, 32'h148, 64'd0, 11);

    // Write miss to an empty line allocates, then merges.
    push_mem(0, 27'h13, 0, '0);
    access("t5 wr 0x260", 0, 1, 32'h260, 64'h55, 6);
    exp_rd.push_back(64'h55);
    access("t5 rd 0x260", 1, 0, 32'h260, 64'd0, 0);
    exp_rd.push_back(pat(27'h13, 3));
    access("t5 rd 0x278", 1, 0, 32'h278, 64'd0, 0);

    // Evict the merged line and confirm the store reaches memory.
    push_mem(1, 27'h13, 1, {pat(27'h13, 3), pat(27'h13, 2), pat(27'h13, 1), 64'h55});
    push_mem(0, 27'h1B, 0, '0); exp_rd.push_back(pat(27'h1B, 0));
    access("t7 rd 0x360", 1, 0, 32'h360, 64'd0, 11);
    access("t7 wr 0x368", 0, 1, 32'h368, 64'hCAFE, 0);

    // Reset while refilling: the miss is abandoned and dirty data is lost.
    proc_read = 1'b1; proc_addr = 30'(32'h40 >> 2);
    #1;
    check("t6 miss stall", 256'(proc_stall), 256'(1));
    @(posedge clk); @(negedge clk); #1;
    check("t6 alloc mem_read", 256'(mem_read), 256'(1));
    check("t6 alloc mem_addr", 256'(mem_addr), 256'(27'h2));
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6 abandon mem_read", 256'(mem_read), 256'(0));
    check("t6 abandon mem_write", 256'(mem_write), 256'(0));
    proc_read = 1'b0;
    push_mem(0, 27'h2, 0, '0); exp_rd.push_back(pat(27'h2, 0));
    access("t6 rd 0x40", 1, 0, 32'h40, 64'd0, 6);
    push_mem(0, 27'h1B, 0, '0); exp_rd.push_back(pat(27'h1B, 1));
    access("t6 rd 0x368", 1, 0, 32'h368, 64'd0, 6);

    check("leftover mem reqs", 256'(exp_mem.size()), 256'(0));
    check("leftover reads", 256'(exp_rd.size()), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
